crc16_serial_divider: RTL and testbench



---
 rtl/crc16_serial_divider.sv | 115 +++++++++++
 tb/tb_crc16_serial_divider.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/crc16_serial_divider.sv
// Bit-serial CRC-16 long divider: shifts a DATA_W+CRC_W frame MSB-first
// through a remainder register. Optional CRC16_ERR_CNT_EN adds err_cnt/err_clr.
module crc16_serial_divider #(
    parameter int              DATA_W = 4,
    parameter int              CRC_W  = 16,
    parameter logic [CRC_W-1:0] POLY  = 16'h8005
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DATA_W+CRC_W-1:0]   frame_in,
    output logic                      busy,
    output logic                      done,
    output logic [CRC_W-1:0]          crc_out,
    output logic                      zero_rem
`ifdef CRC16_ERR_CNT_EN
    ,
    input  logic                      err_clr,
    output logic [7:0]                err_cnt
`endif
);

    localparam int FRAME_W = DATA_W + CRC_W;
    localparam int CNT_W   = $clog2(FRAME_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [FRAME_W-1:0]   sr;
    logic [CRC_W-1:0]     rem;
    logic [CRC_W-1:0]     rem_nxt;
    logic [CNT_W-1:0]     cnt;
    logic                 last;
    logic                 load;

    // One long-division step: bring in the next dividend bit, subtract on carry-out.
    always_comb begin
        rem_nxt = {rem[CRC_W-2:0], sr[FRAME_W-1]} ^ (rem[CRC_W-1] ? POLY : '0);
    end

    assign last = (cnt == CNT_W'(FRAME_W - 1));
    assign load = start && (state != SHIFT);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and status outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = start ? SHIFT : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shift register, remainder, bit counter and held result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr       <= '0;
            rem      <= '0;
            cnt      <= '0;
            crc_out  <= '0;
            zero_rem <= 1'b0;
        end else if (load) begin
            sr  <= frame_in;
            rem <= '0;
            cnt <= '0;
        end else if (state == SHIFT) begin
            rem <= rem_nxt;
            sr  <= {sr[FRAME_W-2:0], 1'b0};
            cnt <= cnt + CNT_W'(1);
            if (last) begin
                crc_out  <= rem_nxt;
                zero_rem <= (rem_nxt == '0);
            end
        end
    end

`ifdef CRC16_ERR_CNT_EN
    // Saturating count of failed checks; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (done && !zero_rem && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_crc16_serial_divider.sv
// Directed bench for crc16_serial_divider; expected CRCs hand-computed
// for POLY 16'h8005, init 0, no reflection.
module tb_crc16_serial_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic [19:0] frame_in;
    logic        busy;
    logic        done;
    logic [15:0] crc_out;
    logic        zero_rem;
`ifdef CRC16_ERR_CNT_EN
    logic        err_clr;
    logic [7:0]  err_cnt;
`endif

    int total;
    int bad;

    crc16_serial_divider dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .frame_in (frame_in),
        .busy     (busy),
        .done     (done),
        .crc_out  (crc_out),
        .zero_rem (zero_rem)
`ifdef CRC16_ERR_CNT_EN
        ,
        .err_clr  (err_clr),
        .err_cnt  (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a frame, return with done visible; lat = edges after accept edge.
    task automatic run(input logic [19:0] f, output int lat);
        start    = 1'b1;
        frame_in = f;
        tick();
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    int lat;
    int sp;
    logic seen;

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        start    = 1'b0;
        frame_in = '0;
`ifdef CRC16_ERR_CNT_EN
        err_clr  = 1'b0;
`endif
        tick();
        tick();
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_crc", {16'd0, crc_out}, 0);
        chk("rst_zr", {31'd0, zero_rem}, 0);
        rst = 1'b0;
        tick();

        // data 1, zeros appended
        run({4'h1, 16'h0000}, lat);
        chk("lat1", lat, 20);
        chk("crc1", {16'd0, crc_out}, 32'h8005);
        chk("zr1", {31'd0, zero_rem}, 0);
        chk("busy_in_done", {31'd0, busy}, 0);
        tick();
        chk("done_pulse", {31'd0, done}, 0);
        tick();
        chk("crc1_held", {16'd0, crc_out}, 32'h8005);

        // reset in the middle of a division
        start    = 1'b1;
        frame_in = {4'h3, 16'h0000};
        tick();
        start = 1'b0;
        chk("busy_run", {31'd0, busy}, 1);
        repeat (9) tick();
        rst = 1'b1;
        #1;
        chk("mid_busy", {31'd0, busy}, 0);
        chk("mid_done", {31'd0, done}, 0);
        chk("mid_crc", {16'd0, crc_out}, 0);
        tick();
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        chk("no_done", {31'd0, seen}, 0);
        run({4'h1, 16'h0000}, lat);
        chk("lat_after_rst", lat, 20);
        chk("crc_after_rst", {16'd0, crc_out}, 32'h8005);
        tick();

        run({4'h2, 16'h0000}, lat);
        chk("crc2", {16'd0, crc_out}, 32'h800F);
        tick();
        run({4'h0, 16'h0000}, lat);
        chk("crc0", {16'd0, crc_out}, 32'h0000);
        chk("zr0", {31'd0, zero_rem}, 1);
        tick();

        // check mode
        run({4'h1, 16'h8005}, lat);
        chk("chk_ok", {16'd0, crc_out}, 0);
        chk("chk_ok_zr", {31'd0, zero_rem}, 1);
        tick();
        run({4'h1, 16'h8004}, lat);
        chk("chk_bad", {16'd0, crc_out}, 32'h0001);
        chk("chk_bad_zr", {31'd0, zero_rem}, 0);
        tick();

        // start while busy ignored; start in DONE accepted
        start    = 1'b1;
        frame_in = {4'h2, 16'h0000};
        tick();
        start = 1'b0;
        repeat (5) tick();
        start    = 1'b1;
        frame_in = {4'h1, 16'h0000};
        tick();
        start    = 1'b0;
        frame_in = {4'hF, 16'hFFFF};
        lat = 6;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        chk("ign_lat", lat, 20);
        chk("ign_crc", {16'd0, crc_out}, 32'h800F);
        start    = 1'b1;
        frame_in = {4'h1, 16'h0000};
        tick();
        start = 1'b0;
        chk("b2b_busy", {31'd0, busy}, 1);
        sp = 1;
        while (!done && sp < 40) begin
            tick();
            sp++;
        end
        chk("b2b_space", sp, 21);
        chk("b2b_crc", {16'd0, crc_out}, 32'h8005);
        tick();

`ifdef CRC16_ERR_CNT_EN
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("ec_clr", {24'd0, err_cnt}, 0);
        for (int i = 0; i < 3; i++) begin
            run({4'h1, 16'h8004}, lat);
            tick();
        end
        chk("ec_3", {24'd0, err_cnt}, 3);
        run({4'h1, 16'h8004}, lat);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("ec_clr_win", {24'd0, err_cnt}, 0);
        run({4'h1, 16'h8005}, lat);
        tick();
        chk("ec_pass", {24'd0, err_cnt}, 0);
        for (int i = 0; i < 300; i++) begin
            run({4'h1, 16'h8004}, lat);
            tick();
        end
        chk("ec_sat", {24'd0, err_cnt}, 32'hFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
